// File: rtl/shvar_pipe.sv
// Pipelined variable-amount barrel shifter (SRL/SRA/SLL/ROR) with predicate and valid/ready flow control.
// Optional `SHVAR_PIPE_STICKY_EN adds o0_sticky, the OR of all bits shifted out of the operand.
module shvar_pipe #(
    parameter int width     = 32,
    parameter int shiftbits = 6,
    parameter int stages    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           op,
    input  logic                 pred,
    input  logic [width-1:0]     i0,
    input  logic [shiftbits-1:0] amt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 o0_valid,
    input  logic                 o0_ready,
    output logic                 o0_enable,
`ifdef SHVAR_PIPE_STICKY_EN
    output logic                 o0_sticky,
`endif
    output logic [width-1:0]     o0
);

    localparam int LOG = $clog2(width);

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    logic             vld_q  [stages];
    logic             vld_d  [stages];
    op_e              op_q   [stages];
    op_e              op_d   [stages];
    logic             pred_q [stages];
    logic             pred_d [stages];
    logic             oor_q  [stages];
    logic             oor_d  [stages];
    logic [LOG-1:0]   amt_q  [stages];
    logic [LOG-1:0]   amt_d  [stages];
    logic [width-1:0] data_q [stages];
    logic [width-1:0] data_d [stages];
`ifdef SHVAR_PIPE_STICKY_EN
    logic             sticky_q [stages];
    logic             sticky_d [stages];
`endif

    logic stall;

    assign o0_valid  = vld_q[stages-1];
    assign o0_enable = pred_q[stages-1];
    assign o0        = data_q[stages-1];
    assign stall     = o0_valid & ~o0_ready;
    assign in_ready  = ~stall;
`ifdef SHVAR_PIPE_STICKY_EN
    assign o0_sticky = sticky_q[stages-1];
`endif

    // Stage s applies every level k with floor(k*stages/LOG) == s; the range override lands in the last stage.
    always_comb begin
        logic [width-1:0]   d;
        logic [2*width-1:0] wide;
        logic [width-1:0]   ones;
        op_e                o;
        logic [LOG-1:0]     a;
        logic               v;
        logic               p;
        logic               ov;
        int                 ps;
        int                 sh;
`ifdef SHVAR_PIPE_STICKY_EN
        logic               st;
        st   = 1'b0;
`endif
        d    = '0;
        wide = '0;
        ones = '1;
        o    = OP_SRL;
        a    = '0;
        v    = 1'b0;
        p    = 1'b0;
        ov   = 1'b0;
        ps   = 0;
        sh   = 0;
        for (int s = 0; s < stages; s++) begin
            ps = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                v  = in_valid;
                o  = op_e'(op);
                p  = pred;
                a  = amt[LOG-1:0];
                ov = |(amt >> LOG);
                d  = i0;
`ifdef SHVAR_PIPE_STICKY_EN
                st = ov & (op_e'(op) != OP_ROR) & (|i0);
`endif
            end else begin
                v  = vld_q[ps];
                o  = op_q[ps];
                p  = pred_q[ps];
                a  = amt_q[ps];
                ov = oor_q[ps];
                d  = data_q[ps];
`ifdef SHVAR_PIPE_STICKY_EN
                st = sticky_q[ps];
`endif
            end
            for (int k = 0; k < LOG; k++) begin
                if ((((k * stages) / LOG) == s) && a[k]) begin
                    sh = 1 << k;
                    unique case (o)
                        OP_SRL: begin
`ifdef SHVAR_PIPE_STICKY_EN
                            st = st | (|(d & (ones >> (width - sh))));
`endif
                            d = d >> sh;
                        end
                        OP_SRA: begin
`ifdef SHVAR_PIPE_STICKY_EN
                            st = st | (|(d & (ones >> (width - sh))));
`endif
                            wide = {{width{d[width-1]}}, d} >> sh;
                            d    = wide[width-1:0];
                        end
                        OP_SLL: begin
`ifdef SHVAR_PIPE_STICKY_EN
                            st = st | (|(d & ~(ones >> sh)));
`endif
                            d = d << sh;
                        end
                        OP_ROR: begin
                            wide = {d, d} >> sh;
                            d    = wide[width-1:0];
                        end
                    endcase
                end
            end
            // An arithmetic shift never disturbs the MSB, so d[width-1] is still the operand's sign here.
            if ((s == stages - 1) && ov && (o != OP_ROR)) begin
                d = (o == OP_SRA) ? {width{d[width-1]}} : '0;
            end
            vld_d[s]  = v;
            op_d[s]   = o;
            pred_d[s] = p;
            oor_d[s]  = ov;
            amt_d[s]  = a;
            data_d[s] = d;
`ifdef SHVAR_PIPE_STICKY_EN
            sticky_d[s] = st;
`endif
        end
    end

    // Whole pipe holds on stall, otherwise every stage advances; bubbles move like words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < stages; s++) begin
                vld_q[s]  <= 1'b0;
                op_q[s]   <= OP_SRL;
                pred_q[s] <= 1'b0;
                oor_q[s]  <= 1'b0;
                amt_q[s]  <= '0;
                data_q[s] <= '0;
`ifdef SHVAR_PIPE_STICKY_EN
                sticky_q[s] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            for (int s = 0; s < stages; s++) begin
                vld_q[s]  <= vld_d[s];
                op_q[s]   <= op_d[s];
                pred_q[s] <= pred_d[s];
                oor_q[s]  <= oor_d[s];
                amt_q[s]  <= amt_d[s];
                data_q[s] <= data_d[s];
`ifdef SHVAR_PIPE_STICKY_EN
                sticky_q[s] <= sticky_d[s];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (width >= 2 && (width & (width - 1)) == 0);
        assert (shiftbits >= LOG);
        assert (stages >= 1 && stages <= shiftbits);
    end

endmodule
